alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream issue/capture stage for the 4-bit alushifter (ops m=0000..1111).
//  Accepts one operation request per valid/ready handshake and drives a, b, cin
//  and m to the alushifter from registers. It waits a fixed settle time, then
//  captures r/of into a result register and presents it downstream with
//  valid/ready. Holds an accumulator so consecutive ops can chain on the last result.
// PARAMETERS
//  WIDTH   4   operand/result width; must match alushifter data width
//  SETTLE  1   edges from accept to capture (>=1); covers combinational ALU delay
// PORTS
//  clk       in   1      sole clock, rising edge
//  rst       in   1      synchronous, active-high reset
//  in_valid  in   1      request valid
//  in_ready  out  1      request accepted when in_valid&in_ready at clk edge
//  in_a      in   WIDTH  operand A (ignored when in_chain=1)
//  in_b      in   WIDTH  operand B
//  in_cin    in   1      carry-in
//  in_m      in   4      alushifter mode code
//  in_chain  in   1      1: A operand = accumulator instead of in_a
//  alu_a     out  WIDTH  registered to alushifter a
//  alu_b     out  WIDTH  registered to alushifter b
//  alu_cin   out  1      registered to alushifter cin
//  alu_m     out  4      registered to alushifter m
//  alu_r     in   WIDTH  alushifter result r
//  alu_of    in   1      alushifter overflow of
//  out_valid out  1      result valid
//  out_ready in   1      downstream accepts when out_valid&out_ready at edge
//  out_r     out  WIDTH  captured result
//  out_of    out  1      captured overflow
//  op_count  out  8      completed (output-handshaked) ops, wraps 255->0
// BEHAVIOUR
//  - Reset (sync, any state): state=IDLE; out_valid=0; out_r=0; out_of=0;
//    alu_a/b/m/cin=0; acc=0; op_count=0; settle counter=0. Reset mid-op
//    aborts it: no out_valid, no op_count change.
//  - FSM IDLE -> WAIT -> DONE -> IDLE. in_ready = (state==IDLE), combinational.
//  - IDLE: on in_valid at edge, latch alu_a <= in_chain ? acc : in_a;
//    alu_b/cin/m <= in_*; cnt <= SETTLE; go to WAIT. No request -> stay IDLE.
//  - WAIT: each edge cnt--. On the edge where cnt==1, out_r<=alu_r,
//    out_of<=alu_of, acc<=alu_r, out_valid<=1, go to DONE.
//    out_valid rises exactly SETTLE edges after the accept edge.
//  - DONE: out_valid/out_r/out_of held stable until out_ready at an edge;
//    then out_valid<=0, op_count++ (mod 256), go to IDLE.
//  - in_valid outside IDLE: ignored, no latch. No overlap of ops; one op
//    per SETTLE+2 cycles max (assuming out_ready already high).
//  - alu_* held after capture until the next accept (never cleared).
//  - All arithmetic is done by the alushifter; this block only registers.
//    acc is WIDTH bits, no extension.
// TESTING
//  1 reset, req a=0010 b=0011 m=0000 cin=0, out_ready=1 -> out_valid 1 edge
//    after accept, out_r=0101, op_count=1, in_ready back to 1 the next cycle
//  2 after test 1, req chain=1 b=0001 m=0000 -> alu_a=0101, out_r=0110
//  3 out_ready=0 for 5 cycles in DONE -> out_valid/out_r stable, in_ready=0,
//    pulses of in_valid ignored, op_count unchanged until out_ready=1
//  4 SETTLE=3, a=1001 m=1110 (rotate left) -> alu_* stable across 3 edges,
//    out_valid on 3rd edge, out_r=0011
//  5 rst asserted in WAIT -> next cycle out_valid=0, acc=0, op_count=0,
//    in_ready=1; a following chain op uses A=0000
//  6 256 back-to-back ops with out_ready=1 -> op_count wraps 255->0

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Purpose: issue/capture stage for the 4-bit alushifter; registers one op, captures r/of, holds an accumulator for chaining.
// Latency: out_valid rises SETTLE edges after the accept edge; at most one op per SETTLE+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready at an edge.
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   in_valid/in_ready             request handshake; in_a/in_b/in_cin/in_m/in_chain request fields
//   alu_a/alu_b/alu_cin/alu_m     registered operands to the alushifter
//   alu_r/alu_of                  alushifter result, sampled SETTLE edges after accept
//   out_valid/out_ready           result handshake; out_r/out_of captured result
//   op_count                      output-handshaked ops, wraps 255->0
module alu_op_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [3:0]       in_m,
    input  logic             in_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [3:0]       alu_m,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_of,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_of,
    output logic [7:0]       op_count
);

    // Counter must hold the value SETTLE itself.
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             alu_cin_q, alu_cin_d;
    logic [3:0]       alu_m_q, alu_m_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_r_q, out_r_d;
    logic             out_of_q, out_of_d;
    logic [7:0]       op_count_q, op_count_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_m_d     = alu_m_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_of_d    = out_of_q;
        op_count_d  = op_count_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    alu_a_d   = in_chain ? acc_q : in_a;
                    alu_b_d   = in_b;
                    alu_cin_d = in_cin;
                    alu_m_d   = in_m;
                    cnt_d     = CW'(SETTLE);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                // Operands have been stable for SETTLE edges on the edge where cnt==1.
                if (cnt_q == CW'(1)) begin
                    out_r_d     = alu_r;
                    out_of_d    = alu_of;
                    acc_d       = alu_r;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_m_q     <= 4'd0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_of_q    <= 1'b0;
            op_count_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_m_q     <= alu_m_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_of_q    <= out_of_d;
            op_count_q  <= op_count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign alu_m     = alu_m_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_of    = out_of_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose: bench for alu_op_sequencer, SETTLE=1 and SETTLE=3 instances against a small alushifter stand-in.
// Latency: checks accept-to-valid timing and handshake-to-idle timing cycle by cycle.
// Backpressure: exercises out_ready held low in DONE and ignored in_valid pulses.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stand-in alushifter: m=0000 add with carry (of = signed overflow), m=1110 rotate left by one.
    function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic cin, input logic [3:0] m);
        logic [3:0] r;
        logic       of;
        r  = a & b;
        of = 1'b0;
        if (m == 4'b0000) begin
            r  = a + b + {3'b000, cin};
            of = (a[3] == b[3]) && (r[3] != a[3]);
        end else if (m == 4'b1110) begin
            r = {a[2:0], a[3]};
        end
        return {of, r};
    endfunction

    // Instance 1: SETTLE=1
    logic       rst1, in_valid1, in_ready1, in_cin1, in_chain1, alu_cin1, alu_of1, out_valid1, out_ready1, out_of1;
    logic [3:0] in_a1, in_b1, in_m1, alu_a1, alu_b1, alu_m1, alu_r1, out_r1;
    logic [7:0] op_count1;
    assign {alu_of1, alu_r1} = alu_model(alu_a1, alu_b1, alu_cin1, alu_m1);

    alu_op_sequencer #(.WIDTH(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst1),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1), .in_m(in_m1), .in_chain(in_chain1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_cin(alu_cin1), .alu_m(alu_m1),
        .alu_r(alu_r1), .alu_of(alu_of1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_r(out_r1), .out_of(out_of1),
        .op_count(op_count1)
    );

    // Instance 3: SETTLE=3
    logic       rst3, in_valid3, in_ready3, in_cin3, in_chain3, alu_cin3, alu_of3, out_valid3, out_ready3, out_of3;
    logic [3:0] in_a3, in_b3, in_m3, alu_a3, alu_b3, alu_m3, alu_r3, out_r3;
    logic [7:0] op_count3;
    assign {alu_of3, alu_r3} = alu_model(alu_a3, alu_b3, alu_cin3, alu_m3);

    alu_op_sequencer #(.WIDTH(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst3),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .in_cin(in_cin3), .in_m(in_m3), .in_chain(in_chain3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_cin(alu_cin3), .alu_m(alu_m3),
        .alu_r(alu_r3), .alu_of(alu_of3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_r(out_r3), .out_of(out_of3),
        .op_count(op_count3)
    );

    // Scoreboards: {of, r} expected per issued op.
    logic [4:0] q1[$];
    logic [4:0] q3[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors pop on every output handshake.
    always @(negedge clk) begin
        if (out_valid1 && out_ready1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL sb1_unexpected: got %0h expected no result", {out_of1, out_r1});
            end else begin
                logic [4:0] e;
                e = q1.pop_front();
                if ({out_of1, out_r1} !== e) begin
                    errors++;
                    $display("FAIL sb1_result: got %0h expected %0h", {out_of1, out_r1}, e);
                end
            end
        end
        if (out_valid3 && out_ready3) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL sb3_unexpected: got %0h expected no result", {out_of3, out_r3});
            end else begin
                logic [4:0] e;
                e = q3.pop_front();
                if ({out_of3, out_r3} !== e) begin
                    errors++;
                    $display("FAIL sb3_result: got %0h expected %0h", {out_of3, out_r3}, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents one request for one edge, pushes the expectation.
    task automatic send(input int d, input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic [3:0] m, input logic chain, input logic push, input logic [4:0] exp);
        int n;
        n = 0;
        while (((d == 1) ? !in_ready1 : !in_ready3) && n < 50) begin
            step();
            n++;
        end
        if ((d == 1) ? !in_ready1 : !in_ready3) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
        if (d == 1) begin
            in_a1 = a; in_b1 = b; in_cin1 = cin; in_m1 = m; in_chain1 = chain; in_valid1 = 1'b1;
            if (push) q1.push_back(exp);
        end else begin
            in_a3 = a; in_b3 = b; in_cin3 = cin; in_m3 = m; in_chain3 = chain; in_valid3 = 1'b1;
            if (push) q3.push_back(exp);
        end
        step();
        in_valid1 = 1'b0;
        in_valid3 = 1'b0;
    endtask

    // Waits (bounded) until the instance is back in IDLE.
    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (((d == 1) ? !in_ready1 : !in_ready3) && n < 50) begin
            step();
            n++;
        end
        if ((d == 1) ? !in_ready1 : !in_ready3) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got in_ready 0 expected 1");
        end
    endtask

    initial begin
        rst1 = 1'b1; in_valid1 = 1'b0; in_a1 = 4'd0; in_b1 = 4'd0; in_cin1 = 1'b0; in_m1 = 4'd0;
        in_chain1 = 1'b0; out_ready1 = 1'b1;
        rst3 = 1'b1; in_valid3 = 1'b0; in_a3 = 4'd0; in_b3 = 4'd0; in_cin3 = 1'b0; in_m3 = 4'd0;
        in_chain3 = 1'b0; out_ready3 = 1'b1;
        step();
        step();
        rst1 = 1'b0;
        rst3 = 1'b0;

        // Reset state
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_in_ready", in_ready1, 1);
        chk("rst_out_r", out_r1, 0);
        chk("rst_op_count", op_count1, 0);
        chk("rst_alu_a", alu_a1, 0);
        chk("rst3_in_ready", in_ready3, 1);

        // Test 1: 0010 + 0011 = 0101, one-edge latency
        send(1, 4'b0010, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b1, 5'b0_0101);
        chk("t1_alu_a", alu_a1, 4'b0010);
        chk("t1_valid_early", out_valid1, 0);
        chk("t1_in_ready_busy", in_ready1, 0);
        step();
        chk("t1_valid", out_valid1, 1);
        chk("t1_out_r", out_r1, 4'b0101);
        step();
        chk("t1_valid_drop", out_valid1, 0);
        chk("t1_in_ready_back", in_ready1, 1);
        chk("t1_op_count", op_count1, 1);

        // Test 2: chain on accumulator, 0101 + 0001 = 0110
        send(1, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 5'b0_0110);
        chk("t2_alu_a_acc", alu_a1, 4'b0101);
        wait_idle(1);
        chk("t2_op_count", op_count1, 2);

        // Test 3: backpressure; 0111 + 0001 = 1000 with signed overflow
        out_ready1 = 1'b0;
        send(1, 4'b0111, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 5'b1_1000);
        step();
        for (int k = 0; k < 5; k++) begin
            in_valid1 = k[0];
            in_a1 = 4'b1111;
            in_chain1 = 1'b0;
            chk("t3_valid_held", out_valid1, 1);
            chk("t3_out_r_held", {out_of1, out_r1}, 5'b1_1000);
            chk("t3_in_ready_low", in_ready1, 0);
            chk("t3_count_held", op_count1, 2);
            step();
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        step();
        chk("t3_valid_drop", out_valid1, 0);
        chk("t3_op_count", op_count1, 3);
        chk("t3_alu_a_not_relatched", alu_a1, 4'b0111);

        // Test 4: SETTLE=3, rotate left 1001 -> 0011
        send(3, 4'b1001, 4'b0000, 1'b0, 4'b1110, 1'b0, 1'b1, 5'b0_0011);
        chk("t4_alu_a", alu_a3, 4'b1001);
        chk("t4_alu_m", alu_m3, 4'b1110);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t4_alu_a_stable", alu_a3, 4'b1001);
            chk("t4_valid_timing", out_valid3, (k == 3) ? 1 : 0);
        end
        chk("t4_out_r", out_r3, 4'b0011);
        step();
        chk("t4_op_count", op_count3, 1);

        // Test 5: reset during WAIT aborts the op and clears the accumulator
        send(3, 4'b0101, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 5'b0);
        step();
        rst3 = 1'b1;
        step();
        rst3 = 1'b0;
        chk("t5_valid", out_valid3, 0);
        chk("t5_in_ready", in_ready3, 1);
        chk("t5_op_count", op_count3, 0);
        chk("t5_alu_a", alu_a3, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_no_valid", out_valid3, 0);
        end
        send(3, 4'b1111, 4'b0011, 1'b0, 4'b0000, 1'b1, 1'b1, 5'b0_0011);
        chk("t5_chain_acc0", alu_a3, 4'b0000);
        wait_idle(3);
        chk("t5_op_count_after", op_count3, 1);

        // Test 6: 256 back-to-back ops, op_count wraps 255 -> 0
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        chk("t6_rst_count", op_count1, 0);
        for (int i = 0; i < 255; i++) begin
            logic [7:0] iv;
            iv = i[7:0];
            send(1, iv[3:0], 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, {1'b0, iv[3:0]});
        end
        wait_idle(1);
        chk("t6_count_255", op_count1, 255);
        send(1, 4'b1010, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 5'b0_1010);
        wait_idle(1);
        chk("t6_count_wrap", op_count1, 0);

        step();
        chk("sb1_drained", q1.size(), 0);
        chk("sb3_drained", q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
